// File: rtl/mct_pkg.sv
// Shared encodings for the multi-channel compare timer.
// Channel state enumeration and one-shot/periodic mode values.
package mct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mct_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/mct_channel.sv
// One timer channel: FSM, latched limit/mode, up-counter, equality compare
// and the registered hit/done/busy outputs.
module mct_channel
    import mct_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             hit,
    output logic             done
);

    mct_state_t       state;
    logic [WIDTH-1:0] lim_q;
    logic             mode_q;

    // Channel FSM with counter; start outranks stop and any pending match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            lim_q  <= {WIDTH{1'b0}};
            mode_q <= MODE_ONESHOT;
            cnt    <= {WIDTH{1'b0}};
            busy   <= 1'b0;
            hit    <= 1'b0;
            done   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (start) begin
                lim_q  <= limit;
                mode_q <= mode;
                cnt    <= {WIDTH{1'b0}};
                done   <= 1'b0;
                busy   <= 1'b1;
                state  <= ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (stop) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (tick) begin
                            if (cnt == lim_q) begin
                                hit <= 1'b1;
                                case (mode_q)
                                    MODE_PERIODIC: cnt <= {WIDTH{1'b0}};
                                    MODE_ONESHOT: begin
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= ST_DONE;
                                    end
                                    default: begin
                                        busy  <= 1'b0;
                                        state <= ST_IDLE;
                                    end
                                endcase
                            end else begin
                                // Equality compare means cnt never passes lim_q, so no wrap.
                                cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                        state <= state;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_cmp_timer.sv
// NCH independent compare timers sharing one tick source.
// Optional shared prescaler enabled by defining MCT_PRESCALER_EN.
module multi_cmp_timer
    import mct_pkg::*;
#(
    parameter int NCH     = 4,
`ifdef MCT_PRESCALER_EN
    parameter int PRESC_W = 8,
`endif
    parameter int WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*WIDTH-1:0] limit,
`ifdef MCT_PRESCALER_EN
    input  logic [PRESC_W-1:0]   presc,
`endif
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       hit,
    output logic [NCH-1:0]       done
);

    logic tick;

`ifdef MCT_PRESCALER_EN
    logic [PRESC_W-1:0] div;
    logic [PRESC_W-1:0] presc_q;

    // Free-running divider; the divide value is only reloaded at wrap so a
    // change mid-period can never strand div above the new terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= {PRESC_W{1'b0}};
            presc_q <= {PRESC_W{1'b0}};
        end else if (div == presc_q) begin
            div     <= {PRESC_W{1'b0}};
            presc_q <= presc;
        end else begin
            div <= div + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (div == presc_q);
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mct_channel #(.WIDTH(WIDTH)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .start (start[i]),
            .stop  (stop[i]),
            .mode  (mode[i]),
            .limit (limit[i*WIDTH +: WIDTH]),
            .cnt   (cnt[i*WIDTH +: WIDTH]),
            .busy  (busy[i]),
            .hit   (hit[i]),
            .done  (done[i])
        );
    end

endmodule

// File: tb/tb_multi_cmp_timer.sv
// Scoreboard bench for multi_cmp_timer: expectations derived from start times
// are queued per cycle and compared on the falling edge.
module tb_multi_cmp_timer;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       start, stop, mode;
    logic [NCH*WIDTH-1:0] limit;
    logic [NCH*WIDTH-1:0] cnt;
    logic [NCH-1:0]       busy, hit, done;
`ifdef MCT_PRESCALER_EN
    logic [7:0]           presc;
`endif

    multi_cmp_timer #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .limit (limit),
`ifdef MCT_PRESCALER_EN
        .presc (presc),
`endif
        .cnt   (cnt),
        .busy  (busy),
        .hit   (hit),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int exp;
    } sb_ent_t;

    sb_ent_t sb[$];
    sb_ent_t mon_e;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int obs(input int kind, input int ch);
        case (kind)
            0:       return int'(cnt[ch*WIDTH +: WIDTH]);
            1:       return int'(busy[ch]);
            2:       return int'(hit[ch]);
            default: return int'(done[ch]);
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            0:       return "cnt";
            1:       return "busy";
            2:       return "hit";
            default: return "done";
        endcase
    endfunction

    function automatic void sb_push(input int c, input int kind, input int ch, input int ex);
        sb_ent_t e;
        int i;
        e.cyc = c; e.kind = kind; e.ch = ch; e.exp = ex;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    // Queue expectations for one channel at one cycle; -1 skips a field.
    function automatic void expect4(input int c, input int ch, input int cn,
                                    input int bs, input int ht, input int dn);
        if (cn >= 0) sb_push(c, 0, ch, cn);
        if (bs >= 0) sb_push(c, 1, ch, bs);
        if (ht >= 0) sb_push(c, 2, ch, ht);
        if (dn >= 0) sb_push(c, 3, ch, dn);
    endfunction

    // Compare every queued expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_eq($sformatf("%s%0d@%0d", kname(mon_e.kind), mon_e.ch, mon_e.cyc),
                     obs(mon_e.kind, mon_e.ch), mon_e.exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start on the masked channels; s is the cycle index of the sampling edge.
    task automatic pulse_start(input logic [NCH-1:0] m, input int lim, input logic md,
                               input logic with_stop, output int s);
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                limit[i*WIDTH +: WIDTH] = lim[WIDTH-1:0];
                mode[i] = md;
            end
        end
        start = m;
        if (with_stop) stop = m;
        @(posedge clk);
        #1;
        s = cyc;
        start = '0;
        stop  = '0;
    endtask

    task automatic pulse_stop(input logic [NCH-1:0] m);
        stop = m;
        @(posedge clk);
        #1;
        stop = '0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        do begin
            @(posedge clk);
            #1;
            b++;
        end while (sb.size() > 0 && b < 600);
        check_eq("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int s, s2;
        rst   = 1'b1;
        start = '0;
        stop  = '0;
        mode  = '0;
        limit = '0;
`ifdef MCT_PRESCALER_EN
        presc = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_cnt", int'(cnt), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_hit", int'(hit), 0);
        check_eq("rst_done", int'(done), 0);
        step(2);

        // One-shot, limit 5
        pulse_start(4'b0001, 5, 1'b0, 1'b0, s);
        for (int j = 0; j <= 5; j++) expect4(s + j, 0, j, 1, 0, 0);
        expect4(s + 6, 0, 5, 0, 1, 1);
        for (int j = 7; j <= 9; j++) expect4(s + j, 0, 5, 0, 0, 1);
        drain();

        // Periodic, limit 3
        pulse_start(4'b0010, 3, 1'b1, 1'b0, s);
        for (int j = 0; j <= 12; j++)
            expect4(s + j, 1, j % 4, 1, (j >= 4 && j % 4 == 0) ? 1 : 0, 0);
        drain();
        pulse_stop(4'b0010);

        // Periodic, limit 0
        pulse_start(4'b0100, 0, 1'b1, 1'b0, s);
        expect4(s, 2, 0, 1, 0, 0);
        for (int j = 1; j <= 5; j++) expect4(s + j, 2, 0, 1, 1, 0);
        drain();
        pulse_stop(4'b0100);

        // One-shot, full-range limit
        pulse_start(4'b1000, 255, 1'b0, 1'b0, s);
        expect4(s + 254, 3, 254, 1, 0, 0);
        expect4(s + 255, 3, 255, 1, 0, 0);
        expect4(s + 256, 3, 255, 0, 1, 1);
        expect4(s + 257, 3, 255, 0, 0, 1);
        drain();

        // Stop at cnt = 2
        pulse_start(4'b0001, 5, 1'b0, 1'b0, s);
        for (int j = 0; j <= 2; j++) expect4(s + j, 0, j, 1, 0, 0);
        for (int j = 3; j <= 8; j++) expect4(s + j, 0, 2, 0, 0, 0);
        step(2);
        pulse_stop(4'b0001);
        drain();

        // Start and stop together
        pulse_start(4'b0001, 4, 1'b0, 1'b1, s);
        for (int j = 0; j <= 2; j++) expect4(s + j, 0, j, 1, 0, 0);
        drain();

        // Restart exactly on the match cycle suppresses that hit
        pulse_start(4'b0010, 2, 1'b1, 1'b0, s);
        for (int j = 0; j <= 2; j++) expect4(s + j, 1, j, 1, 0, 0);
        expect4(s + 3, 1, 0, 1, 0, 0);
        expect4(s + 4, 1, 1, 1, 0, 0);
        expect4(s + 5, 1, 2, 1, 0, 0);
        expect4(s + 6, 1, 0, 1, 1, 0);
        step(2);
        pulse_start(4'b0010, 2, 1'b1, 1'b0, s2);
        check_eq("restart_edge", s2 - s, 3);
        drain();
        pulse_stop(4'b0010);

        // Async reset with every channel running
        pulse_start(4'b1111, 100, 1'b1, 1'b0, s);
        step(5);
        check_eq("pre_rst_busy", int'(busy), 15);
        check_eq("pre_rst_cnt0", int'(cnt[WIDTH-1:0]), 5);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_cnt", int'(cnt), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_hit", int'(hit), 0);
        check_eq("arst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);
        check_eq("post_rst_busy", int'(busy), 0);
        check_eq("post_rst_cnt", int'(cnt), 0);

`ifdef MCT_PRESCALER_EN
        begin
            int seen, k;
            presc = 8'd3;
            step(10);
            pulse_start(4'b0001, 2, 1'b0, 1'b0, s);
            seen = 0;
            k = 0;
            while (seen == 0 && k < 16) begin
                @(negedge clk);
                k++;
                if (hit[0]) seen = 1;
            end
            check_eq("psc_hit", seen, 1);
            check_eq("psc_slow", (k >= 9) ? 1 : 0, 1);
            #1;
            check_eq("psc_done", int'(done[0]), 1);
            presc = 8'd0;
            step(10);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
